// File: rtl/mp_addsub_pkg.sv
// Shared encodings and sizing helper for the limb-serial multi-precision adder/subtractor.
package mp_addsub_pkg;

  // Operation select; bit 0 is the subtract bit, bit 1 selects the accumulate source.
  localparam logic [1:0] MODE_ADD     = 2'b00;
  localparam logic [1:0] MODE_SUB     = 2'b01;
  localparam logic [1:0] MODE_ACC_ADD = 2'b10;
  localparam logic [1:0] MODE_ACC_SUB = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFin  = 2'd2
  } state_e;

  // Number of limbs needed to hold an (opw+1)-bit value: ceil((opw+1)/lw).
  function automatic int unsigned nlimb(input int unsigned opw, input int unsigned lw);
    return (opw + lw) / lw;
  endfunction

endpackage

// File: rtl/mp_addsub_limb.sv
// Combinational single-limb adder with carry-in and optional inversion of the right operand.
module mp_addsub_limb #(
  parameter int unsigned LIMB_W = 64
) (
  input  logic [LIMB_W-1:0] i_a,
  input  logic [LIMB_W-1:0] i_b,
  input  logic              i_cin,
  input  logic              i_invert_b,
  output logic [LIMB_W-1:0] o_sum,
  output logic              o_cout
);

  logic [LIMB_W-1:0] w_b;
  logic [LIMB_W:0]   w_full;

  // Subtraction is A + ~B + 1; the +1 arrives through the carry-in of limb 0.
  always_comb begin
    w_b    = i_invert_b ? ~i_b : i_b;
    w_full = {1'b0, i_a} + {1'b0, w_b} + {{LIMB_W{1'b0}}, i_cin};
    o_sum  = w_full[LIMB_W-1:0];
    o_cout = w_full[LIMB_W];
  end

endmodule

// File: rtl/mp_addsub_serial.sv
// Limb-serial multi-precision adder/subtractor with accumulate modes and in-place right shift.
// One LIMB_W-bit limb is processed per cycle; the result register only changes at reset,
// at the end of an operation, or on a shift.
module mp_addsub_serial
  import mp_addsub_pkg::*;
#(
  parameter int unsigned OPERAND_W = 514,
  parameter int unsigned LIMB_W    = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 shift,
  input  logic [OPERAND_W-1:0] in_a,
  input  logic [OPERAND_W-1:0] in_b,
  output logic [OPERAND_W:0]   result,
  output logic                 done,
  output logic                 busy
);

  localparam int unsigned NLIMB = nlimb(OPERAND_W, LIMB_W);
  localparam int unsigned EXT_W = NLIMB * LIMB_W;
  localparam int unsigned RES_W = OPERAND_W + 1;
  localparam int unsigned KW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  state_e              r_state;
  logic [EXT_W-1:0]    r_a;      // shadow left operand, shifted down one limb per cycle
  logic [EXT_W-1:0]    r_b;      // shadow right operand, shifted down one limb per cycle
  logic [EXT_W-1:0]    r_sum;    // shadow sum, limbs enter at the top and drift down
  logic                r_sub;
  logic                r_carry;
  logic [KW-1:0]       r_k;
  logic [RES_W-1:0]    r_result;
  logic                r_done;
  logic                r_busy;

  logic [EXT_W-1:0]    w_a_ext;
  logic [EXT_W-1:0]    w_b_ext;
  logic [LIMB_W-1:0]   w_limb_sum;
  logic                w_limb_cout;
  logic [EXT_W-1:0]    w_sum_ins;
  logic                w_unused_sum_hi;

  // Operand extension at acceptance: acc modes take the current result as the left operand.
  always_comb begin
    w_a_ext = mode[1] ? EXT_W'(r_result) : EXT_W'(in_a);
    w_b_ext = EXT_W'(in_b);
  end

  mp_addsub_limb #(
    .LIMB_W (LIMB_W)
  ) u_limb (
    .i_a        (r_a[LIMB_W-1:0]),
    .i_b        (r_b[LIMB_W-1:0]),
    .i_cin      (r_carry),
    .i_invert_b (r_sub),
    .o_sum      (w_limb_sum),
    .o_cout     (w_limb_cout)
  );

  // New limb is placed in the top slot; after NLIMB shifts limb 0 sits at the bottom.
  always_comb begin
    w_sum_ins = EXT_W'(w_limb_sum) << (EXT_W - LIMB_W);
  end

  // Bits above OPERAND_W are discarded by the modulo 2^(OPERAND_W+1) arithmetic.
  assign w_unused_sum_hi = ^(r_sum >> RES_W);

  // Control FSM, datapath shadow registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_k      <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            // Start beats a simultaneous shift request.
            r_a     <= w_a_ext;
            r_b     <= w_b_ext;
            r_sub   <= mode[0];
            r_carry <= mode[0];
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= StCalc;
          end else if (shift) begin
            r_result <= {1'b0, r_result[RES_W-1:1]};
          end
        end
        StCalc: begin
          r_a     <= r_a >> LIMB_W;
          r_b     <= r_b >> LIMB_W;
          r_sum   <= (r_sum >> LIMB_W) | w_sum_ins;
          r_carry <= w_limb_cout;
          r_k     <= r_k + 1'b1;
          if (r_k == KW'(NLIMB - 1)) begin
            r_busy  <= 1'b0;
            r_state <= StFin;
          end
        end
        StFin: begin
          r_result <= r_sum[RES_W-1:0];
          r_done   <= 1'b1;
          r_state  <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = r_busy;

endmodule

// File: tb/tb_mp_addsub_serial.sv
// Directed self-checking bench for mp_addsub_serial at the default limb width and at LIMB_W=32.
module tb_mp_addsub_serial;

  localparam int OW = 514;
  localparam int RW = 515;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, shift;
  logic [1:0]    mode;
  logic [OW-1:0] in_a, in_b;
  logic [RW-1:0] result;
  logic          done, busy;

  logic          start2, shift2;
  logic [1:0]    mode2;
  logic [OW-1:0] in_a2, in_b2;
  logic [RW-1:0] result2;
  logic          done2, busy2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mp_addsub_serial #(.OPERAND_W(OW), .LIMB_W(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .shift  (shift),
    .in_a   (in_a),
    .in_b   (in_b),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  mp_addsub_serial #(.OPERAND_W(OW), .LIMB_W(32)) dut32 (
    .clk    (clk),
    .reset  (reset),
    .start  (start2),
    .mode   (mode2),
    .shift  (shift2),
    .in_a   (in_a2),
    .in_b   (in_b2),
    .result (result2),
    .done   (done2),
    .busy   (busy2)
  );

  // Launch one operation on the 64-bit DUT and wait (bounded) for done.
  // lat counts edges from acceptance to the edge after which done is seen.
  task automatic run_op(input logic [1:0] m, input logic [OW-1:0] a, input logic [OW-1:0] b,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; mode = m; in_a = a; in_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (result !== '0) begin n_err++; $display("FAIL reset_result got %0h want 0", result); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (result2 !== '0) begin n_err++; $display("FAIL reset_result32 got %0h want 0", result2); end
    n_vec++; if (done2 !== 1'b0) begin n_err++; $display("FAIL reset_done32 got %b want 0", done2); end
    n_vec++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL reset_busy32 got %b want 0", busy2); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add_basic();
    int lat, bc;
    run_op(2'b00, OW'(1), OW'(1), lat, bc);
    n_vec++; if (lat !== 10) begin n_err++; $display("FAIL add_latency got %0d want 10", lat); end
    n_vec++; if (result !== RW'(2)) begin n_err++; $display("FAIL add_1p1 got %0h want 2", result); end
    n_vec++; if (bc !== 9) begin n_err++; $display("FAIL add_busy_cycles got %0d want 9", bc); end
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_carry();
    int lat, bc;
    logic [RW-1:0] exp;
    logic [OW-1:0] a;
    a = '0; a[63:0] = '1;
    exp = '0; exp[64] = 1'b1;
    run_op(2'b00, a, OW'(1), lat, bc);
    n_vec++; if (result !== exp) begin n_err++; $display("FAIL carry_limb got %0h want %0h", result, exp); end
    a = '1;
    exp = '1; exp = exp - 1'b1;
    run_op(2'b00, a, a, lat, bc);
    n_vec++; if (result !== exp) begin n_err++; $display("FAIL carry_full got %0h want %0h", result, exp); end
    n_vec++; if (result[OW] !== 1'b1) begin n_err++; $display("FAIL carry_msb got %b want 1", result[OW]); end
  endtask

  task automatic test_sub();
    int lat, bc;
    logic [RW-1:0] exp;
    run_op(2'b01, OW'(1), OW'(1), lat, bc);
    n_vec++; if (result !== '0) begin n_err++; $display("FAIL sub_1m1 got %0h want 0", result); end
    exp = '1;
    run_op(2'b01, OW'(1), OW'(2), lat, bc);
    n_vec++; if (result !== exp) begin n_err++; $display("FAIL sub_1m2 got %0h want %0h", result, exp); end
    n_vec++; if (result[OW] !== 1'b1) begin n_err++; $display("FAIL sub_borrow got %b want 1", result[OW]); end
  endtask

  task automatic test_acc_chain();
    int lat, bc;
    run_op(2'b00, OW'(2), OW'(0), lat, bc);
    n_vec++; if (result !== RW'(2)) begin n_err++; $display("FAIL acc_seed got %0h want 2", result); end
    run_op(2'b10, OW'(16'hDEAD), OW'(3), lat, bc);
    n_vec++; if (result !== RW'(5)) begin n_err++; $display("FAIL acc_add got %0h want 5", result); end
    run_op(2'b11, OW'(16'hDEAD), OW'(1), lat, bc);
    n_vec++; if (result !== RW'(4)) begin n_err++; $display("FAIL acc_sub got %0h want 4", result); end
    @(negedge clk);
    shift = 1'b1;
    @(posedge clk); #1;
    shift = 1'b0;
    n_vec++; if (result !== RW'(2)) begin n_err++; $display("FAIL shift_result got %0h want 2", result); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL shift_no_done got %b want 0", done); end
  endtask

  task automatic test_ignore_while_busy();
    int dcount;
    dcount = 0;
    @(negedge clk);
    start = 1'b1; mode = 2'b00; in_a = OW'(5); in_b = OW'(7);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 2 && i <= 6) begin
        start = 1'b1; shift = 1'b1; mode = 2'b01; in_a = OW'(100); in_b = OW'(100);
      end else begin
        start = 1'b0; shift = 1'b0;
      end
      @(posedge clk); #1;
      if (done) dcount++;
    end
    n_vec++; if (dcount !== 1) begin n_err++; $display("FAIL busy_done_count got %0d want 1", dcount); end
    n_vec++; if (result !== RW'(12)) begin n_err++; $display("FAIL busy_ignore got %0h want 12", result); end
  endtask

  task automatic test_start_shift_idle();
    int lat;
    @(negedge clk);
    start = 1'b1; shift = 1'b1; mode = 2'b00; in_a = OW'(3); in_b = OW'(4);
    @(posedge clk); #1;
    start = 1'b0; shift = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL startshift_busy got %b want 1", busy); end
    n_vec++; if (result !== RW'(12)) begin n_err++; $display("FAIL startshift_noshift got %0h want 12", result); end
    lat = 0;
    while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    n_vec++; if (result !== RW'(7)) begin n_err++; $display("FAIL startshift_result got %0h want 7", result); end
  endtask

  task automatic test_reset_abort();
    int dcount;
    @(negedge clk);
    start = 1'b1; mode = 2'b00; in_a = OW'(1); in_b = OW'(1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (result !== '0) begin n_err++; $display("FAIL abort_result got %0h want 0", result); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    n_vec++; if (dcount !== 0) begin n_err++; $display("FAIL abort_no_done got %0d want 0", dcount); end
    n_vec++; if (result !== '0) begin n_err++; $display("FAIL abort_hold got %0h want 0", result); end
  endtask

  task automatic test_limb32();
    int lat, bc;
    @(negedge clk);
    start2 = 1'b1; mode2 = 2'b00; in_a2 = OW'(1); in_b2 = OW'(1);
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = 0;
    bc = busy2 ? 1 : 0;
    while (!done2 && lat < 80) begin
      @(posedge clk); #1;
      lat++;
      if (busy2) bc++;
    end
    n_vec++; if (lat !== 18) begin n_err++; $display("FAIL l32_latency got %0d want 18", lat); end
    n_vec++; if (result2 !== RW'(2)) begin n_err++; $display("FAIL l32_result got %0h want 2", result2); end
    n_vec++; if (bc !== 17) begin n_err++; $display("FAIL l32_busy_cycles got %0d want 17", bc); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; shift = 1'b0; mode = 2'b00; in_a = '0; in_b = '0;
    start2 = 1'b0; shift2 = 1'b0; mode2 = 2'b00; in_a2 = '0; in_b2 = '0;
    test_reset();
    test_add_basic();
    test_carry();
    test_sub();
    test_acc_chain();
    test_ignore_while_busy();
    test_start_shift_idle();
    test_reset_abort();
    test_limb32();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
